// File: rtl/cpu_run_controller.sv
// cpu_run_controller: sequences the single-cycle LegV8 core with reset hold, run/pause, single-step, PC breakpoint and sticky halt
module cpu_run_controller #(
    parameter int PC_W       = 8,
    parameter int DIV        = 256,
    parameter int RST_CYCLES = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             run_btn_i,
    input  logic             step_btn_i,
    input  logic             bp_en_i,
    input  logic [PC_W-1:0]  bp_pc_i,
    input  logic [PC_W-1:0]  pc_i,
    input  logic             halt_in_i,
    output logic             cpu_rst_o,
    output logic             cpu_ce_o,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] instr_count_o,
    output logic             halted_o
);

    localparam int PSC_W = DIV > 1 ? $clog2(DIV) : 1;
    localparam int RC_W  = RST_CYCLES > 1 ? $clog2(RST_CYCLES) : 1;
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(DIV - 1);
    localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(RST_CYCLES - 1);

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        PAUSE = 3'd1,
        RUN   = 3'd2,
        STEP  = 3'd3,
        HALT  = 3'd4
    } state_e;

    state_e state_q, state_d;
    logic [1:0] run_sync_q, step_sync_q;
    logic run_prev_q, step_prev_q;
    logic run_ev, step_ev;
    logic [PSC_W-1:0] psc_q, psc_d;
    logic [RC_W-1:0] rcnt_q, rcnt_d;
    logic bp_skip_q, bp_skip_d;
    logic cpu_rst_q, cpu_rst_d;
    logic cpu_ce_q, cpu_ce_d;
    logic halted_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic tick, bp_hit;

    // two-flop synchronizers plus the previous synchronized level for edge detection
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_sync_q  <= '0;
            step_sync_q <= '0;
            run_prev_q  <= 1'b0;
            step_prev_q <= 1'b0;
        end else begin
            run_sync_q  <= {run_sync_q[0], run_btn_i};
            step_sync_q <= {step_sync_q[0], step_btn_i};
            run_prev_q  <= run_sync_q[1];
            step_prev_q <= step_sync_q[1];
        end
    end

    assign run_ev  = run_sync_q[1] & ~run_prev_q;
    assign step_ev = step_sync_q[1] & ~step_prev_q;
    assign tick    = psc_q == PSC_LAST;
    assign bp_hit  = bp_en_i && (pc_i == bp_pc_i) && !bp_skip_q;

    // next-state logic: every output is computed here and registered below
    always_comb begin
        state_d   = state_q;
        psc_d     = '0;
        rcnt_d    = rcnt_q;
        bp_skip_d = bp_skip_q;
        cpu_rst_d = 1'b0;
        cpu_ce_d  = 1'b0;
        case (state_q)
            INIT: begin
                cpu_rst_d = rcnt_q != RC_LAST;
                state_d   = rcnt_q == RC_LAST ? PAUSE : INIT;
                rcnt_d    = rcnt_q == RC_LAST ? rcnt_q : rcnt_q + 1'b1;
            end
            PAUSE: begin
                state_d   = run_ev ? RUN : step_ev ? STEP : PAUSE;
                bp_skip_d = run_ev ? 1'b1 : bp_skip_q;
            end
            RUN: begin
                psc_d = (tick || run_ev) ? '0 : psc_q + 1'b1;
                if (halt_in_i) begin
                    state_d = HALT;
                end else if (run_ev || (tick && bp_hit)) begin
                    state_d = PAUSE;
                end else if (tick) begin
                    cpu_ce_d  = 1'b1;
                    bp_skip_d = 1'b0;
                end
            end
            // the pulse is issued while still in STEP; the cycle after it returns to PAUSE
            STEP: begin
                state_d  = cpu_ce_q ? PAUSE : halt_in_i ? HALT : STEP;
                cpu_ce_d = !cpu_ce_q && !halt_in_i;
            end
            HALT: state_d = HALT;
            default: begin
                state_d   = INIT;
                cpu_rst_d = 1'b1;
            end
        endcase
        cnt_d = cnt_q + CNT_W'(cpu_ce_d);
    end

    // state and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= INIT;
            psc_q     <= '0;
            rcnt_q    <= '0;
            bp_skip_q <= 1'b0;
            cpu_rst_q <= 1'b1;
            cpu_ce_q  <= 1'b0;
            cnt_q     <= '0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            psc_q     <= psc_d;
            rcnt_q    <= rcnt_d;
            bp_skip_q <= bp_skip_d;
            cpu_rst_q <= cpu_rst_d;
            cpu_ce_q  <= cpu_ce_d;
            cnt_q     <= cnt_d;
            halted_q  <= state_d == HALT;
        end
    end

    assign state_o       = state_q;
    assign cpu_rst_o     = cpu_rst_q;
    assign cpu_ce_o      = cpu_ce_q;
    assign instr_count_o = cnt_q;
    assign halted_o      = halted_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// tb_cpu_run_controller: directed and randomized checks of cpu_run_controller against a behavioural model
module tb_cpu_run_controller;

    localparam int PC_W       = 8;
    localparam int DIV        = 4;
    localparam int RST_CYCLES = 4;
    localparam int CNT_W      = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic run_btn = 1'b0;
    logic step_btn = 1'b0;
    logic bp_en = 1'b0;
    logic halt_in = 1'b0;
    logic [PC_W-1:0] bp_pc = '0;
    logic [PC_W-1:0] pc;
    logic cpu_rst, cpu_ce, halted;
    logic [2:0] state;
    logic [CNT_W-1:0] instr_count;

    int checks = 0;
    int errors = 0;

    int m_state, m_rst_left, m_phase;
    bit m_rst, m_ce, m_halt, m_skip, m_step_done;
    logic [CNT_W-1:0] m_cnt;
    bit rh[3];
    bit sh[3];

    int n, t0, first, pulses, doubles, seen_run, got;
    bit prev_ce;
    logic [CNT_W-1:0] c0;

    always #5 clk = ~clk;

    cpu_run_controller #(
        .PC_W(PC_W), .DIV(DIV), .RST_CYCLES(RST_CYCLES), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .run_btn_i(run_btn), .step_btn_i(step_btn),
        .bp_en_i(bp_en), .bp_pc_i(bp_pc), .pc_i(pc), .halt_in_i(halt_in),
        .cpu_rst_o(cpu_rst), .cpu_ce_o(cpu_ce), .state_o(state),
        .instr_count_o(instr_count), .halted_o(halted)
    );

    // stand-in processor: PC advances by one instruction on every enabled edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc <= '0;
        else if (cpu_rst) pc <= '0;
        else if (cpu_ce) pc <= pc + 8'd4;
    end

    task automatic check_eq(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got_v, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_rst_left = RST_CYCLES;
        m_rst = 1;
        m_ce = 0;
        m_halt = 0;
        m_cnt = '0;
        m_phase = 0;
        m_skip = 0;
        m_step_done = 0;
        for (int i = 0; i < 3; i++) begin
            rh[i] = 0;
            sh[i] = 0;
        end
    endtask

    // predicts the outputs after the coming edge from the inputs held across it
    task automatic model_step();
        bit rev, sev, tk, nce;
        rev = rh[1] && !rh[2];
        sev = sh[1] && !sh[2];
        nce = 0;
        if (m_state == 0) begin
            m_rst_left--;
            if (m_rst_left == 0) begin
                m_state = 1;
                m_rst = 0;
            end
        end else if (m_state == 1) begin
            if (rev) begin
                m_state = 2;
                m_phase = 0;
                m_skip = 1;
            end else if (sev) begin
                m_state = 3;
                m_step_done = 0;
            end
        end else if (m_state == 2) begin
            tk = (m_phase % DIV) == DIV - 1;
            m_phase++;
            if (halt_in) m_state = 4;
            else if (rev) m_state = 1;
            else if (tk && bp_en && pc == bp_pc && !m_skip) m_state = 1;
            else if (tk) begin
                nce = 1;
                m_skip = 0;
            end
        end else if (m_state == 3) begin
            if (m_step_done) m_state = 1;
            else if (halt_in) m_state = 4;
            else begin
                nce = 1;
                m_step_done = 1;
            end
        end
        m_ce = nce;
        if (nce) m_cnt++;
        m_halt = m_state == 4;
        rh[2] = rh[1]; rh[1] = rh[0]; rh[0] = run_btn;
        sh[2] = sh[1]; sh[1] = sh[0]; sh[0] = step_btn;
    endtask

    task automatic compare_all();
        check_eq("state", state, m_state);
        check_eq("cpu_rst", cpu_rst, m_rst);
        check_eq("cpu_ce", cpu_ce, m_ce);
        check_eq("instr_count", instr_count, m_cnt);
        check_eq("halted", halted, m_halt);
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        compare_all();
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();

        n = 0;
        for (int i = 0; i < 20 && cpu_rst; i++) begin
            n++;
            cyc();
        end
        check_eq("init_rst_cycles", n, RST_CYCLES);
        check_eq("init_state", state, 1);
        check_eq("init_ce", cpu_ce, 0);
        check_eq("init_cnt", instr_count, 0);

        t0 = -1; first = -1; pulses = 0;
        run_btn = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (i == 10) run_btn = 1'b0;
            cyc();
            if (t0 < 0 && state == 3'd2) t0 = i;
            if (cpu_ce && t0 >= 0) begin
                pulses++;
                if (first < 0) first = i;
            end
            if (t0 >= 0 && i == t0 + 40) break;
        end
        check_eq("run_first_pulse", first - t0, DIV);
        check_eq("run_pulses", pulses, 10);
        check_eq("run_count", instr_count, 10);

        run_btn = 1'b1; cyc(); run_btn = 1'b0; cyc(); cyc();
        check_eq("pause_state", state, 1);
        pulses = 0;
        repeat (12) begin
            cyc();
            pulses += int'(cpu_ce);
        end
        check_eq("pause_no_pulse", pulses, 0);

        c0 = instr_count; pulses = 0; doubles = 0; prev_ce = 0;
        repeat (3) begin
            step_btn = 1'b1;
            for (int k = 0; k < 8; k++) begin
                if (k == 2) step_btn = 1'b0;
                cyc();
                pulses += int'(cpu_ce);
                if (cpu_ce && prev_ce) doubles++;
                prev_ce = cpu_ce;
            end
        end
        check_eq("step_pulses", pulses, 3);
        check_eq("step_single", doubles, 0);
        check_eq("step_count", instr_count, c0 + 3);

        run_btn = 1'b1; step_btn = 1'b1; cyc(); cyc();
        run_btn = 1'b0; step_btn = 1'b0; cyc();
        check_eq("run_step_same", state, 2);

        for (int i = 0; i < 2 * DIV && (m_phase % DIV) != DIV - 3; i++) cyc();
        run_btn = 1'b1; cyc(); run_btn = 1'b0; cyc();
        c0 = instr_count;
        cyc();
        check_eq("collide_state", state, 1);
        check_eq("collide_ce", cpu_ce, 0);
        check_eq("collide_cnt", instr_count, c0);

        do_reset();
        repeat (RST_CYCLES) cyc();
        bp_en = 1'b1; bp_pc = 8'h0C;
        run_btn = 1'b1; cyc(); run_btn = 1'b0;
        seen_run = 0;
        for (int i = 0; i < 80; i++) begin
            cyc();
            if (state == 3'd2) seen_run = 1;
            if (seen_run != 0 && state == 3'd1) break;
        end
        check_eq("bp_state", state, 1);
        check_eq("bp_pc", pc, 8'h0C);
        check_eq("bp_count", instr_count, 3);

        run_btn = 1'b1; cyc(); run_btn = 1'b0;
        got = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (cpu_ce) begin
                got = 1;
                break;
            end
        end
        check_eq("resume_pulse", got, 1);
        cyc();
        check_eq("resume_pc", pc, 8'h10);
        check_eq("resume_count", instr_count, 4);
        for (int i = 0; i < 400 && state != 3'd1; i++) cyc();
        check_eq("rearm_pc", pc, 8'h0C);
        check_eq("rearm_count", instr_count, 67);

        bp_en = 1'b0;
        run_btn = 1'b1; cyc(); run_btn = 1'b0;
        for (int i = 0; i < 20 && !(m_state == 2 && (m_phase % DIV) == DIV - 1); i++) cyc();
        c0 = instr_count;
        halt_in = 1'b1; cyc(); halt_in = 1'b0;
        check_eq("halt_state", state, 4);
        check_eq("halt_flag", halted, 1);
        check_eq("halt_ce", cpu_ce, 0);
        check_eq("halt_cnt", instr_count, c0);
        run_btn = 1'b1; step_btn = 1'b1; repeat (3) cyc();
        run_btn = 1'b0; step_btn = 1'b0; repeat (6) cyc();
        check_eq("halt_sticky", state, 4);
        check_eq("halt_sticky_cnt", instr_count, c0);
        do_reset();
        check_eq("rst_state", state, 0);
        check_eq("rst_cpu_rst", cpu_rst, 1);
        check_eq("rst_cnt", instr_count, 0);
        check_eq("rst_halted", halted, 0);

        repeat (RST_CYCLES) cyc();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) run_btn = ~run_btn;
            if ($urandom_range(0, 7) == 0) step_btn = ~step_btn;
            halt_in = $urandom_range(0, 299) == 0;
            if ($urandom_range(0, 63) == 0) begin
                bp_en = 1'($urandom_range(0, 1));
                bp_pc = 8'($urandom_range(0, 15) * 4);
            end
            if (m_state == 4 && $urandom_range(0, 49) == 0) do_reset();
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
- Sequences the single-cycle LegV8 processor from the board clock domain.
- Holds the core in reset after power-up, then generates a one-cycle clock-enable pulse per instruction at a programmable rate.
- Supports run/pause, single-step, a PC breakpoint and a sticky halt.
- Sits between board inputs (keys, switches) and the processor's clock-enable and reset; exports an instruction counter and state for the displays/LEDs.

Parameters:
- PC_W, 8, width of processor debug PC and breakpoint address
- DIV, 256, clk cycles per instruction tick in RUN (>=1)
- RST_CYCLES, 4, clk cycles cpu_rst is held after rst_n release (>=1)
- CNT_W, 32, width of instr_count

Ports:
- clk  in  1  board clock; single clock domain
- rst_n  in  1  asynchronous active-low reset
- run_btn  in  1  asynchronous level; each rising edge toggles run/pause
- step_btn  in  1  asynchronous level; rising edge executes one instruction while paused
- bp_en  in  1  breakpoint enable
- bp_pc  in  PC_W  breakpoint address
- pc  in  PC_W  processor current PC (debug_pc_out)
- halt_in  in  1  processor halt condition (sentinel result), synchronous to clk
- cpu_rst  out  1  active-high processor reset
- cpu_ce  out  1  processor clock enable; one pulse = one instruction
- state  out  3  INIT=0, PAUSE=1, RUN=2, STEP=3, HALT=4
- instr_count  out  CNT_W  number of cpu_ce pulses issued
- halted  out  1  high in HALT

Behaviour:
- Reset (async, rst_n=0) sets:
  - outputs: state=INIT, cpu_rst=1, cpu_ce=0, instr_count=0, halted=0
  - internals: synchronizers, edge detectors, prescaler and reset counter to 0; bp_skip=0
- All outputs are registered. Reset asserted mid-operation aborts immediately to the reset values.
- Input conditioning: run_btn and step_btn each pass through a 2-flop synchronizer, then a rising-edge detector (1-cycle event pulse). The FSM acts on an event at the edge after the pulse. No debouncing; the board wrapper owns that.
- INIT:
  - cpu_rst=1 for exactly RST_CYCLES clk cycles after rst_n rises.
  - Then state=PAUSE and cpu_rst=0, both on the same edge.
  - Button events are ignored during INIT.
- PAUSE:
  - run event: state=RUN, prescaler=0, bp_skip=1.
  - Otherwise step event: state=STEP.
  - Run and step events in the same cycle: run wins.
- RUN:
  - Prescaler counts 0..DIV-1 and wraps; tick when prescaler==DIV-1.
  - First tick occurs DIV cycles after entering RUN.
  - Priority each cycle (highest first):
    1. halt_in=1: state=HALT, no pulse.
    2. run event: state=PAUSE, no pulse, prescaler=0; this wins over a coincident tick.
    3. tick with bp_en=1, pc==bp_pc and bp_skip=0: state=PAUSE, no pulse.
    4. tick otherwise: cpu_ce=1 for one cycle and bp_skip=0.
  - step events in RUN are ignored.
- STEP:
  - halt_in=1: state=HALT, no pulse.
  - Otherwise: cpu_ce=1 for exactly one cycle, then state=PAUSE on the next edge.
  - Breakpoint is not checked in STEP.
- HALT:
  - halted=1, cpu_ce=0; sticky until rst_n.
  - All button events ignored.
- cpu_ce rules:
  - Never high in INIT, PAUSE or HALT.
  - Never high for two consecutive cycles unless DIV=1 in RUN; with DIV=1 it is continuous.
- instr_count:
  - Increments on the same edge that sets cpu_ce=1, so it includes the current pulse.
  - Wraps modulo 2^CNT_W; cleared only by reset.
- A breakpoint PC re-armed after resume stops again on its next occurrence. bp_skip only suppresses the first tick after resume.

Test Plan:
- Reset and init (DIV=4, RST_CYCLES=4): release rst_n -> cpu_rst=1 for 4 cycles, then state=1, cpu_ce=0, instr_count=0.
- Free run: run_btn rise held 10 cycles, then 40 cycles in RUN -> cpu_ce pulses every 4th cycle; first pulse 4 cycles after state=2; instr_count=10.
- Pause/step: run edge in RUN -> state=1 with no further pulses. Three step edges -> exactly 3 single-cycle cpu_ce pulses; instr_count +3. A simultaneous run+step edge in PAUSE -> state=2.
- Breakpoint: bp_en=1, bp_pc=0x0C; model pc increments by 4 per pulse from 0 -> pause with pc=0x0C after 3 pulses. Resume -> next pulse issued despite pc==0x0C.
- Halt: halt_in=1 asserted coincident with a tick in RUN -> state=4, halted=1, no pulse. Later run/step edges -> no change. rst_n low mid-HALT -> all reset values.
- Tick vs pause collision: run edge timed on the tick cycle -> state=1, no cpu_ce, instr_count unchanged.
